move_dir_scheduler: RTL and testbench
=====================================

// Module: move_dir_scheduler
// PURPOSE
//  Sequences the direction validator across all 8 compass directions for one candidate move.
//  For each direction it loads the start square and step into the validator, starts it,
//  and waits for its done pulse. It then records the result in a direction mask.
//  Sits between the new-move controller (requester) and the validator (resource).
//  Reports overall legality plus the per-direction mask that the flip stage consumes.
// PARAMETERS
//  ADDR_W      7   board address width; address arithmetic is modulo 2^ADDR_W
//  ROW_STRIDE  10  address distance between rows of the padded 10x10 board
//  TIMEOUT_CYC 31  max cycles in WAIT before a direction is forced to fail (>=4)
// PORTS
//  clock          in   1       system clock
//  reset          in   1       sync, active-low
//  start          in   1       1-cycle request; sampled only in IDLE
//  player         in   1       0=black, 1=white; latched on accepted start
//  s_addr_in      in   ADDR_W  candidate square; latched on accepted start
//  busy           out  1       high from the cycle after accepted start until DONE exits
//  done           out  1       1-cycle pulse; legal/dir_mask/timeout_o valid in this cycle and held after
//  legal          out  1       |dir_mask
//  dir_mask       out  8       bit d = direction d brackets opponent stones
//  timeout_o      out  1       any direction of this scan hit TIMEOUT_CYC
//  ld_vali_o      out  1       1-cycle load strobe to validator
//  start_vali_o   out  1       1-cycle enable strobe to validator
//  s_addr_out     out  ADDR_W  latched candidate square, stable while busy
//  player_o       out  1       latched player, stable while busy
//  step_o         out  ADDR_W  two's-complement step of the current direction, modulo 2^ADDR_W
//  s_done_in      in   1       validator done pulse
//  dir_status_in  in   1       validator result; qualified by s_done_in
// BEHAVIOUR
//  Reset (reset==0 at posedge): state=IDLE, dir=0, all outputs 0. Applies from any state.
//    Outputs are 0 in the cycle after that edge.
//  Direction order d=0..7 with step = N:-S, NE:-S+1, E:+1, SE:+S+1, S:+S, SW:+S-1, W:-1, NW:-S-1.
//    S = ROW_STRIDE.
//  step_o is registered and updates on entry to LOAD.
//  States:
//   IDLE:   start=1 latches s_addr_in/player; clears dir_mask, timeout_o, dir -> LOAD.
//   LOAD:   ld_vali_o=1 for exactly 1 cycle; step_o=step(dir) -> KICK.
//   KICK:   start_vali_o=1 for exactly 1 cycle; wdog=0 -> WAIT.
//   WAIT:   if s_done_in: dir_mask[dir]<=dir_status_in -> NEXT.
//           else if wdog==TIMEOUT_CYC-1: dir_mask[dir]<=0, timeout_o<=1 -> NEXT.
//           else wdog++.
//   NEXT:   if dir==7 -> DONE; else dir++ -> LOAD.
//           The 1-cycle gap lets the validator return to its wait state.
//   DONE:   done=1 for 1 cycle -> IDLE.
//  Signal rules:
//   - s_done_in/dir_status_in are ignored outside WAIT.
//   - A done pulse coincident with the timeout cycle wins: the result is recorded, no timeout.
//   - start while busy or in DONE is ignored (not queued).
//   - start coincident with reset==0 is ignored.
//   - legal/dir_mask/timeout_o hold their values in IDLE until the next accepted start.
//   - legal is combinational from dir_mask; all other outputs are registered.
//  Latency (no early exit): 8*(LOAD+KICK+WAIT_n+NEXT) + DONE.
//    WAIT_n = validator cycles until done, counted from KICK.
//  Step arithmetic wraps mod 2^ADDR_W, e.g. -11 -> 7'h75.
// CONFIGURATION
//  EARLY_EXIT_EN defined: NEXT goes to DONE as soon as any mask bit is 1 (first legal direction).
//    Remaining mask bits stay 0. Used for "does any legal move exist" scans.
//  EARLY_EXIT_EN undefined: all 8 directions are always scanned.
// TESTING
//  1. reset=0 for 2 cycles mid-WAIT of dir 3 -> state IDLE, busy=0, all outputs 0, no done.
//  2. start, s_addr_in=7'd44, player=0; model returns status=1 only for dir 2 ->
//     step_o sequence 76,77,01,0B,0A,09,7F,75 (hex); done=1 once; dir_mask=8'h04; legal=1.
//  3. Same start; model returns status=0 on all dirs -> dir_mask=8'h00, legal=0, timeout_o=0.
//  4. Model never asserts s_done_in on dir 5 -> dir 5 times out after 31 WAIT cycles;
//     scan continues to dir 7; timeout_o=1, dir_mask[5]=0.
//  5. start pulsed again during WAIT of dir 1 -> ignored, latched s_addr_out unchanged,
//     exactly one done pulse.
//  6. EARLY_EXIT_EN build, model legal on dir 1 -> done after dir 1's NEXT;
//     dir_mask=8'h02; only 2 ld_vali_o pulses.

Source files
------------

// File: rtl/move_dir_scheduler.sv
// rtl/move_dir_scheduler.sv - sequences the direction validator over the 8 compass directions
// Optional feature macro: EARLY_EXIT_EN stops the scan after the first legal direction.
module move_dir_scheduler #(
  parameter int ADDR_W      = 7,
  parameter int ROW_STRIDE  = 10,
  parameter int TIMEOUT_CYC = 31
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              player,
  input  logic [ADDR_W-1:0] s_addr_in,
  output logic              busy,
  output logic              done,
  output logic              legal,
  output logic [7:0]        dir_mask,
  output logic              timeout_o,
  output logic              ld_vali_o,
  output logic              start_vali_o,
  output logic [ADDR_W-1:0] s_addr_out,
  output logic              player_o,
  output logic [ADDR_W-1:0] step_o,
  input  logic              s_done_in,
  input  logic              dir_status_in
);

  localparam int WDOG_W = $clog2(TIMEOUT_CYC);
`ifdef EARLY_EXIT_EN
  localparam bit EARLY_EXIT = 1'b1;
`else
  localparam bit EARLY_EXIT = 1'b0;
`endif

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_KICK, S_WAIT, S_NEXT, S_DONE} state_t;

  state_t              state_q;
  logic [2:0]          dir_q;
  logic [WDOG_W-1:0]   wdog_q;
  logic [7:0]          mask_q;
  logic                timeout_q;
  logic                busy_q;
  logic                done_q;
  logic                ld_q;
  logic                kick_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                player_q;
  logic [ADDR_W-1:0]   step_q;

  // Steps are taken modulo 2^ADDR_W so negative offsets wrap into the address space.
  function automatic logic [ADDR_W-1:0] dir_step(input logic [2:0] d);
    logic [ADDR_W-1:0] s;
    logic [ADDR_W-1:0] one;
    s   = ADDR_W'(ROW_STRIDE);
    one = ADDR_W'(1);
    case (d)
      3'd0:    dir_step = '0 - s;
      3'd1:    dir_step = '0 - s + one;
      3'd2:    dir_step = one;
      3'd3:    dir_step = s + one;
      3'd4:    dir_step = s;
      3'd5:    dir_step = s - one;
      3'd6:    dir_step = '0 - one;
      default: dir_step = '0 - s - one;
    endcase
  endfunction

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      dir_q     <= '0;
      wdog_q    <= '0;
      mask_q    <= '0;
      timeout_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ld_q      <= 1'b0;
      kick_q    <= 1'b0;
      addr_q    <= '0;
      player_q  <= 1'b0;
      step_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            addr_q    <= s_addr_in;
            player_q  <= player;
            mask_q    <= '0;
            timeout_q <= 1'b0;
            dir_q     <= '0;
            step_q    <= dir_step(3'd0);
            ld_q      <= 1'b1;
            busy_q    <= 1'b1;
            state_q   <= S_LOAD;
          end
        end
        S_LOAD: begin
          ld_q    <= 1'b0;
          kick_q  <= 1'b1;
          state_q <= S_KICK;
        end
        S_KICK: begin
          kick_q  <= 1'b0;
          wdog_q  <= '0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          // A validator done on the final watchdog cycle takes priority over the timeout.
          if (s_done_in) begin
            mask_q[dir_q] <= dir_status_in;
            state_q       <= S_NEXT;
          end else if (wdog_q == WDOG_W'(TIMEOUT_CYC - 1)) begin
            mask_q[dir_q] <= 1'b0;
            timeout_q     <= 1'b1;
            state_q       <= S_NEXT;
          end else begin
            wdog_q <= wdog_q + WDOG_W'(1);
          end
        end
        S_NEXT: begin
          if (dir_q == 3'd7 || (EARLY_EXIT && (|mask_q))) begin
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            dir_q   <= dir_q + 3'd1;
            step_q  <= dir_step(dir_q + 3'd1);
            ld_q    <= 1'b1;
            state_q <= S_LOAD;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign dir_mask     = mask_q;
  assign legal        = |mask_q;
  assign timeout_o    = timeout_q;
  assign ld_vali_o    = ld_q;
  assign start_vali_o = kick_q;
  assign s_addr_out   = addr_q;
  assign player_o     = player_q;
  assign step_o       = step_q;

endmodule

// File: tb/tb_move_dir_scheduler.sv
// tb/tb_move_dir_scheduler.sv - self-checking bench for move_dir_scheduler
module tb_move_dir_scheduler;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       player = 1'b0;
  logic [6:0] s_addr_in = '0;
  logic       busy, done, legal, timeout_o, ld_vali_o, start_vali_o, player_o;
  logic [7:0] dir_mask;
  logic [6:0] s_addr_out, step_o;
  logic       s_done_in, dir_status_in;

  move_dir_scheduler dut (
    .clock(clock), .reset(reset), .start(start), .player(player), .s_addr_in(s_addr_in),
    .busy(busy), .done(done), .legal(legal), .dir_mask(dir_mask), .timeout_o(timeout_o),
    .ld_vali_o(ld_vali_o), .start_vali_o(start_vali_o), .s_addr_out(s_addr_out),
    .player_o(player_o), .step_o(step_o), .s_done_in(s_done_in), .dir_status_in(dir_status_in)
  );

  always #5 clock = ~clock;

  int vectors = 0;
  int miscompares = 0;

  // Validator model: latency per direction counted from the kick, 0 = never answers.
  logic [7:0]      cfg_status = '0;
  logic [7:0][5:0] cfg_lat = '0;
  bit              noise_en = 0;
  int              kick_idx = 0;
  int              cur_dir = 0;
  int              wait_cnt = 0;
  int              done_cnt = 0;
  int              addr_bad = 0;
  logic [6:0]      exp_addr = '0;
  logic            exp_player = 1'b0;
  logic [6:0]      steps[$];

  initial begin
    s_done_in = 1'b0;
    dir_status_in = 1'b0;
    forever begin
      @(negedge clock);
      s_done_in = 1'b0;
      dir_status_in = 1'b0;
      if (!reset) wait_cnt = 0;
      if (noise_en && ld_vali_o) begin
        s_done_in = 1'b1;
        dir_status_in = 1'b1;
      end
      if (wait_cnt > 0) begin
        wait_cnt--;
        if (wait_cnt == 0) begin
          s_done_in = 1'b1;
          dir_status_in = cfg_status[cur_dir];
        end
      end
      if (start_vali_o) begin
        cur_dir = kick_idx;
        kick_idx++;
        wait_cnt = (cur_dir < 8) ? int'(cfg_lat[cur_dir]) : 0;
      end
      if (ld_vali_o) begin
        steps.push_back(step_o);
        if (s_addr_out !== exp_addr || player_o !== exp_player) addr_bad++;
      end
      if (done) done_cnt++;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: each direction costs LOAD+KICK+NEXT plus its wait (capped at the watchdog).
  function automatic void model(input logic [7:0] st, input logic [7:0][5:0] lt,
                                output logic [7:0] m, output bit to, output int cyc, output int nld);
    m = '0; to = 0; cyc = 1; nld = 0;
    for (int d = 0; d < 8; d++) begin
      int w;
      nld++;
      if (lt[d] == 0 || lt[d] > 31) begin
        to = 1; w = 31;
      end else begin
        w = int'(lt[d]); m[d] = st[d];
      end
      cyc += 3 + w;
`ifdef EARLY_EXIT_EN
      if (m != 0) break;
`endif
    end
  endfunction

  function automatic logic [7:0][5:0] mk_lat(input int l, input int nd, input int nl);
    logic [7:0][5:0] r;
    for (int d = 0; d < 8; d++) r[d] = 6'(l);
    if (nd >= 0) r[nd] = 6'(nl);
    return r;
  endfunction

  task automatic run_scan(input string nm, input logic [6:0] a, input logic p,
                          input logic [7:0] st, input logic [7:0][5:0] lt, input bit poke,
                          output logic [7:0] got_mask, output logic got_to);
    logic [7:0] em;
    bit eto;
    int ecyc, enld, bc, guard, bad, pstate;
    int off[8] = '{-10, -9, 1, 11, 10, 9, -1, -11};
    model(st, lt, em, eto, ecyc, enld);
    cfg_status = st; cfg_lat = lt;
    kick_idx = 0; done_cnt = 0; addr_bad = 0; steps.delete();
    exp_addr = a; exp_player = p;
    @(negedge clock);
    s_addr_in = a; player = p; start = 1'b1;
    @(negedge clock);
    start = 1'b0; s_addr_in = ~a; player = ~p;
    bc = 0; guard = 0; pstate = 0;
    while (busy && guard < 2000) begin
      bc++; guard++;
      if (poke && pstate == 0 && kick_idx == 2) begin start = 1'b1; pstate = 1; end
      else start = 1'b0;
      @(negedge clock);
    end
    start = 1'b0;
    chk({nm, " bound"}, 64'(guard < 2000), 64'd1);
    repeat (2) @(negedge clock);
    got_mask = dir_mask; got_to = timeout_o;
    chk({nm, " mask"}, 64'(dir_mask), 64'(em));
    chk({nm, " legal"}, 64'(legal), 64'(em != 0));
    chk({nm, " timeout"}, 64'(timeout_o), 64'(eto));
    chk({nm, " done_pulses"}, 64'(done_cnt), 64'd1);
    chk({nm, " busy_cycles"}, 64'(bc), 64'(ecyc));
    chk({nm, " ld_pulses"}, 64'(steps.size()), 64'(enld));
    chk({nm, " addr_stable"}, 64'(addr_bad), 64'd0);
    chk({nm, " busy_idle"}, 64'(busy), 64'd0);
    bad = 0;
    foreach (steps[i]) if (i < 8 && steps[i] !== 7'((off[i] + 128) % 128)) bad++;
    chk({nm, " steps"}, 64'(bad), 64'd0);
  endtask

  typedef struct {
    logic [7:0]      status;
    logic [7:0][5:0] lat;
    logic [7:0]      exp_mask;
    logic            exp_to;
  } vec_t;

  initial begin
    vec_t tbl[7];
    logic [7:0] gm;
    logic gt;
    int guard;

    tbl[0] = '{8'h04, mk_lat(3, -1, 0), 8'h04, 1'b0};
    tbl[1] = '{8'h00, mk_lat(2, -1, 0), 8'h00, 1'b0};
    tbl[6] = '{8'h02, mk_lat(3, -1, 0), 8'h02, 1'b0};
`ifdef EARLY_EXIT_EN
    tbl[2] = '{8'hFF, mk_lat(4, 5, 0), 8'h01, 1'b0};
    tbl[3] = '{8'hFF, mk_lat(2, 0, 31), 8'h01, 1'b0};
    tbl[4] = '{8'hA5, mk_lat(1, 3, 31), 8'h01, 1'b0};
`else
    tbl[2] = '{8'hFF, mk_lat(4, 5, 0), 8'hDF, 1'b1};
    tbl[3] = '{8'hFF, mk_lat(2, 0, 31), 8'hFF, 1'b0};
    tbl[4] = '{8'hA5, mk_lat(1, 3, 31), 8'hA5, 1'b0};
`endif
    tbl[5] = '{8'h00, mk_lat(5, 7, 0), 8'h00, 1'b1};

    reset = 1'b0;
    repeat (3) @(negedge clock);
    chk("reset_outputs", {busy, done, legal, dir_mask, timeout_o, ld_vali_o, start_vali_o,
                          s_addr_out, player_o, step_o}, 64'd0);
    reset = 1'b1;
    @(negedge clock);

    for (int i = 0; i < 7; i++) begin
      run_scan($sformatf("tbl%0d", i), 7'd44, 1'(i), tbl[i].status, tbl[i].lat, 0, gm, gt);
      chk($sformatf("tbl%0d table_mask", i), 64'(gm), 64'(tbl[i].exp_mask));
      chk($sformatf("tbl%0d table_to", i), 64'(gt), 64'(tbl[i].exp_to));
    end

    // Start pulsed during the wait of direction 1 must be ignored.
    run_scan("restart", 7'd57, 1'b1, 8'h30, mk_lat(10, -1, 0), 1, gm, gt);
    repeat (3) @(negedge clock);
    chk("restart no_second_scan", 64'(busy), 64'd0);

    // Reset held two cycles in the middle of direction 3's wait.
    cfg_status = 8'hFF; cfg_lat = mk_lat(20, -1, 0);
    kick_idx = 0; done_cnt = 0;
    s_addr_in = 7'd33; player = 1'b1; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    guard = 0;
    while (kick_idx < 4 && guard < 1000) begin guard++; @(negedge clock); end
    chk("midreset reached_dir3", 64'(kick_idx), 64'd4);
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("midreset first_cycle", {busy, done, legal, dir_mask, timeout_o, ld_vali_o,
                                 start_vali_o, s_addr_out, player_o, step_o}, 64'd0);
    @(negedge clock);
    chk("midreset outputs", {busy, done, legal, dir_mask, timeout_o, ld_vali_o, start_vali_o,
                             s_addr_out, player_o, step_o}, 64'd0);
    reset = 1'b1;
    repeat (5) @(negedge clock);
    chk("midreset idle", 64'({busy, ld_vali_o}), 64'd0);
    chk("midreset no_done", 64'(done_cnt), 64'd0);

    // Start coincident with reset is dropped.
    reset = 1'b0; start = 1'b1;
    @(negedge clock);
    reset = 1'b1; start = 1'b0;
    repeat (2) @(negedge clock);
    chk("start_in_reset", 64'({busy, ld_vali_o}), 64'd0);

    for (int r = 0; r < 40; r++) begin
      logic [7:0][5:0] lt;
      for (int d = 0; d < 8; d++)
        lt[d] = ($urandom_range(0, 9) == 0) ? 6'd0 : 6'($urandom_range(1, 31));
      noise_en = 1'($urandom_range(0, 1));
      run_scan($sformatf("rnd%0d", r), 7'($urandom), 1'($urandom), 8'($urandom), lt, 0, gm, gt);
    end
    noise_en = 0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
